// File: rtl/csr_timer.sv
// Timer/interrupt slice of the CSR file: 64-bit stable counter, TID/TCFG/TVAL/TICLR
// countdown timer, ECFG local interrupt enables and the registered interrupt request.
module csr_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    input  logic        crmd_ie,
    input  logic [12:0] estat_is_ext,
    output logic        timer_int,
    output logic        int_req,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi
);

    localparam logic [13:0] CSR_ECFG  = 14'h0004;
    localparam logic [13:0] CSR_TID   = 14'h0040;
    localparam logic [13:0] CSR_TCFG  = 14'h0041;
    localparam logic [13:0] CSR_TVAL  = 14'h0042;
    localparam logic [13:0] CSR_TICLR = 14'h0044;

    // LIE bit 10 has no interrupt source behind it and is hardwired to zero.
    localparam logic [12:0] LIE_MASK  = 13'h1BFF;

    logic [63:0] r_cnt;
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic [12:0] r_ecfg;
    logic        r_armed;
    logic        r_timer_int;
    logic        r_int_req;

    logic        w_we_tid;
    logic        w_we_tcfg;
    logic        w_we_ecfg;
    logic        w_ticlr_clr;
    logic [31:0] w_tid_new;
    logic [31:0] w_tcfg_new;
    logic [31:0] w_ecfg_new;
    logic        w_expire;
    logic [12:0] w_pending;
    logic [31:0] w_rdata;
    logic        w_hit;
    logic        w_unused;

    function automatic logic [31:0] merge(input logic [31:0] old_val);
        return (csr_wmask & csr_wdata) | (~csr_wmask & old_val);
    endfunction

    assign w_we_tid    = csr_we && (csr_num == CSR_TID);
    assign w_we_tcfg   = csr_we && (csr_num == CSR_TCFG);
    assign w_we_ecfg   = csr_we && (csr_num == CSR_ECFG);
    assign w_ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wdata[0];

    assign w_tid_new   = merge(r_tid);
    assign w_tcfg_new  = merge(r_tcfg);
    assign w_ecfg_new  = merge({19'd0, r_ecfg});

    assign w_expire    = r_armed && (r_tval == 32'd0);

    // The internal timer line replaces whatever the CSR file reports in IS[11].
    assign w_pending   = {estat_is_ext[12], r_timer_int, estat_is_ext[10:0]};
    assign w_unused    = estat_is_ext[11];

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values, independent of the order of the statements below.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= 64'd0;
            r_tid <= 32'd0;
            r_ecfg <= 13'd0;
        end else begin
            r_cnt <= r_cnt + 64'd1;
            if (w_we_tid)
                r_tid <= w_tid_new;
            if (w_we_ecfg)
                r_ecfg <= w_ecfg_new[12:0] & LIE_MASK;
        end
    end

    // A TCFG write reloads the countdown and wins over a coinciding expiry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tcfg  <= 32'd0;
            r_tval  <= 32'd0;
            r_armed <= 1'b0;
        end else if (w_we_tcfg) begin
            r_tcfg  <= w_tcfg_new;
            r_tval  <= {w_tcfg_new[31:2], 2'b00};
            r_armed <= w_tcfg_new[0];
        end else if (w_expire) begin
            if (r_tcfg[1])
                r_tval <= {r_tcfg[31:2], 2'b00};
            else
                r_armed <= 1'b0;
        end else if (r_armed) begin
            r_tval <= r_tval - 32'd1;
        end
    end

    // Expiry has priority over a TICLR clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_timer_int <= 1'b0;
            r_int_req   <= 1'b0;
        end else begin
            if (w_expire)
                r_timer_int <= 1'b1;
            else if (w_ticlr_clr)
                r_timer_int <= 1'b0;
            r_int_req <= crmd_ie && |(w_pending & r_ecfg);
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_rdata = 32'd0;
        w_hit   = 1'b1;
        case (csr_num)
            CSR_ECFG:  w_rdata = {19'd0, r_ecfg};
            CSR_TID:   w_rdata = r_tid;
            CSR_TCFG:  w_rdata = r_tcfg;
            CSR_TVAL:  w_rdata = r_tval;
            CSR_TICLR: w_rdata = 32'd0;
            default:   w_hit   = 1'b0;
        endcase
    end

    assign csr_rdata = w_rdata;
    assign csr_hit   = w_hit;
    assign timer_int = r_timer_int;
    assign int_req   = r_int_req;
    assign cnt_lo    = r_cnt[31:0];
    assign cnt_hi    = r_cnt[63:32];

endmodule
